data_bus_master_arbiter: RTL and testbench

- Shares the single ibex data bus slave port of the peripheral interconnect between two masters: m0 (core data port) and m1 (DMA / debug access port).
- Sits between the masters and the peripheral address decoder.
- Forwards one master's request per cycle using round-robin arbitration.
- Tracks outstanding transactions so in-order responses go back to the correct master.

---
 rtl/data_bus_master_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_data_bus_master_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_master_arbiter
// Brief    : Shares one ibex data bus slave port between two masters using
//            round-robin arbitration, and routes in-order responses back to
//            their owners. Optional counters: DATA_BUS_ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================

module data_bus_master_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_FIFO_AW      = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_err,

    output logic        protocol_err
`ifdef DATA_BUS_ARB_PERF_CNT_EN
    ,
    output logic [31:0] m0_grant_cnt,
    output logic [31:0] m1_grant_cnt,
    output logic [31:0] contention_cnt
`endif
);

    localparam logic [ID_FIFO_AW:0]   c_max_cnt  = (ID_FIFO_AW + 1)'(MAX_OUTSTANDING);
    localparam logic [ID_FIFO_AW-1:0] c_last_ptr = ID_FIFO_AW'(MAX_OUTSTANDING - 1);

    // Ownership FIFO: one id bit per granted-but-unanswered transaction
    logic [(2**ID_FIFO_AW)-1:0] r_id_mem;
    logic [ID_FIFO_AW-1:0]      r_wr_ptr;
    logic [ID_FIFO_AW-1:0]      r_rd_ptr;
    logic [ID_FIFO_AW:0]        r_count;

    logic r_rr;
    logic r_hold_valid;
    logic r_hold_id;
    logic r_protocol_err;

    logic w_sel;
    logic w_sel_req;
    logic w_fifo_empty;
    logic w_pop;
    logic w_has_space;
    logic w_issue;
    logic w_push;
    logic w_head_id;
    logic w_route;
    logic w_fwd;

    function automatic logic [ID_FIFO_AW-1:0] ptr_inc(input logic [ID_FIFO_AW-1:0] p);
        return (p == c_last_ptr) ? '0 : p + ID_FIFO_AW'(1);
    endfunction

    always_comb begin
        w_sel = r_rr;
        if (r_hold_valid) begin
            w_sel = r_hold_id;
        end else if (m0_req && !m1_req) begin
            w_sel = 1'b0;
        end else if (m1_req && !m0_req) begin
            w_sel = 1'b1;
        end
    end

    assign w_fwd        = !rst;
    assign w_sel_req    = w_sel ? m1_req : m0_req;
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = w_fwd && s_rvalid && !w_fifo_empty;
    // A response retiring this cycle frees a slot for a same-cycle grant
    assign w_has_space  = (r_count != c_max_cnt) || w_pop;
    assign w_issue      = w_fwd && w_has_space && w_sel_req;
    assign w_push       = w_issue && s_gnt;

    assign s_req   = w_issue;
    assign s_we    = w_fwd && (w_sel ? m1_we : m0_we);
    assign s_be    = w_fwd ? (w_sel ? m1_be    : m0_be)    : '0;
    assign s_addr  = w_fwd ? (w_sel ? m1_addr  : m0_addr)  : '0;
    assign s_wdata = w_fwd ? (w_sel ? m1_wdata : m0_wdata) : '0;

    assign m0_gnt = w_push && !w_sel;
    assign m1_gnt = w_push &&  w_sel;

    assign w_head_id = r_id_mem[r_rd_ptr];
    assign w_route   = w_fwd && !w_fifo_empty;

    assign m0_rvalid = w_route && !w_head_id && s_rvalid;
    assign m0_rdata  = (w_route && !w_head_id) ? s_rdata : '0;
    assign m0_err    = w_route && !w_head_id && s_err;
    assign m1_rvalid = w_route &&  w_head_id && s_rvalid;
    assign m1_rdata  = (w_route &&  w_head_id) ? s_rdata : '0;
    assign m1_err    = w_route &&  w_head_id && s_err;

    assign protocol_err = r_protocol_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_mem       <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rr           <= 1'b0;
            r_hold_valid   <= 1'b0;
            r_hold_id      <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_id_mem[r_wr_ptr] <= w_sel;
                r_wr_ptr           <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            // Freeze the selection until the interconnect accepts it
            if (w_push) begin
                r_rr         <= ~w_sel;
                r_hold_valid <= 1'b0;
            end else if (w_issue && !s_gnt) begin
                r_hold_valid <= 1'b1;
                r_hold_id    <= w_sel;
            end

            if (s_rvalid && w_fifo_empty) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

`ifdef DATA_BUS_ARB_PERF_CNT_EN
    logic [31:0] r_m0_grant_cnt;
    logic [31:0] r_m1_grant_cnt;
    logic [31:0] r_contention_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_grant_cnt   <= '0;
            r_m1_grant_cnt   <= '0;
            r_contention_cnt <= '0;
        end else begin
            if (m0_gnt) begin
                r_m0_grant_cnt <= r_m0_grant_cnt + 32'd1;
            end
            if (m1_gnt) begin
                r_m1_grant_cnt <= r_m1_grant_cnt + 32'd1;
            end
            if (m0_req && m1_req && !m0_gnt && !m1_gnt) begin
                r_contention_cnt <= r_contention_cnt + 32'd1;
            end
        end
    end

    assign m0_grant_cnt   = r_m0_grant_cnt;
    assign m1_grant_cnt   = r_m1_grant_cnt;
    assign contention_cnt = r_contention_cnt;
`else
    // Counters are absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_bus_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_master_arbiter
// Brief    : Scoreboard bench for data_bus_master_arbiter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================

module tb_data_bus_master_arbiter;

    localparam logic [31:0] c_m0_addr = 32'h0000_1000;
    localparam logic [31:0] c_m1_addr = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        protocol_err;
`ifdef DATA_BUS_ARB_PERF_CNT_EN
    logic [31:0] m0_grant_cnt, m1_grant_cnt, contention_cnt;
`endif

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic q_gnt[$];
    rsp_t q_rsp[$];
    int   checks = 0;
    int   errors = 0;

    data_bus_master_arbiter #(
        .MAX_OUTSTANDING(2),
        .ID_FIFO_AW     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_be       (m0_be),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m0_err      (m0_err),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_be       (m1_be),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .m1_err      (m1_err),
        .s_req       (s_req),
        .s_we        (s_we),
        .s_be        (s_be),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_gnt       (s_gnt),
        .s_rvalid    (s_rvalid),
        .s_rdata     (s_rdata),
        .s_err       (s_err),
        .protocol_err(protocol_err)
`ifdef DATA_BUS_ARB_PERF_CNT_EN
        ,
        .m0_grant_cnt  (m0_grant_cnt),
        .m1_grant_cnt  (m1_grant_cnt),
        .contention_cnt(contention_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: inputs change just after the rising edge, then wait for
    // the falling edge where monitor and directed checks sample.
    task automatic cyc(input logic a0, input logic a1, input logic g, input logic rv,
                       input logic [31:0] rd, input logic e, input int eg, input int er);
        rsp_t r;
        @(posedge clk);
        #1;
        m0_req = a0; m1_req = a1; s_gnt = g;
        s_rvalid = rv; s_rdata = rd; s_err = e;
        if (eg >= 0) q_gnt.push_back(eg[0]);
        if (er >= 0) begin
            r.id = er[0]; r.err = e; r.data = rd;
            q_rsp.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every grant and every response is matched against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m0_gnt && m1_gnt) begin
                    checks++; errors++;
                    $display("FAIL dual_gnt: got both grants expected one");
                end else if (m0_gnt || m1_gnt) begin
                    checks++;
                    if (q_gnt.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_gnt: got gnt m%0d expected none", m1_gnt);
                    end else begin
                        logic eid;
                        eid = q_gnt.pop_front();
                        if (m1_gnt !== eid || s_addr !== (eid ? c_m1_addr : c_m0_addr)) begin
                            errors++;
                            $display("FAIL gnt_owner: got m%0d addr %h expected m%0d addr %h",
                                     m1_gnt, s_addr, eid, eid ? c_m1_addr : c_m0_addr);
                        end
                    end
                end
                if (m0_rvalid && m1_rvalid) begin
                    checks++; errors++;
                    $display("FAIL dual_rvalid: got both rvalid expected one");
                end else if (m0_rvalid || m1_rvalid) begin
                    checks++;
                    if (q_rsp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rvalid: got rvalid m%0d expected none", m1_rvalid);
                    end else begin
                        rsp_t ex;
                        logic [31:0] act_d, oth_d;
                        logic        act_e;
                        ex    = q_rsp.pop_front();
                        act_d = m1_rvalid ? m1_rdata : m0_rdata;
                        oth_d = m1_rvalid ? m0_rdata : m1_rdata;
                        act_e = m1_rvalid ? m1_err : m0_err;
                        if (m1_rvalid !== ex.id || act_d !== ex.data || act_e !== ex.err || oth_d !== 32'h0) begin
                            errors++;
                            $display("FAIL rsp_route: got m%0d data %h err %0b other %h expected m%0d data %h err %0b other 0",
                                     m1_rvalid, act_d, act_e, oth_d, ex.id, ex.data, ex.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_we = 1'b0; m0_be = 4'hF; m0_addr = c_m0_addr; m0_wdata = 32'hA0A0_0000;
        m1_we = 1'b1; m1_be = 4'h3; m1_addr = c_m1_addr; m1_wdata = 32'hB1B1_0000;
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
        s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_err = 1'b1;

        // Outputs are forced quiet while reset is held, even with live inputs
        @(negedge clk);
        @(negedge clk);
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        chk("rst_s_req", {31'b0, s_req}, 32'd0);
        chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_err", {31'b0, m1_err}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        do_reset();
        cyc(0, 0, 0, 0, 32'h0, 0, -1, -1);
        chk("rst_protocol_err", {31'b0, protocol_err}, 32'd0);

        // Single m0 read with response next cycle
        cyc(1, 0, 1, 0, 32'h0, 0, 0, -1);
        cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 0, -1, 0);
        chk("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        chk("t1_m1_rdata", m1_rdata, 32'd0);
        chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        cyc(0, 0, 0, 0, 32'h0, 0, -1, -1);
        do_reset();

        // Both masters continuously: alternating grants, responses one cycle later
        cyc(1, 1, 1, 0, 32'h0,         0, 0, -1);
        cyc(1, 1, 1, 1, 32'h1111_0000, 0, 1,  0);
        cyc(1, 1, 1, 1, 32'h2222_0001, 1, 0,  1);
        cyc(1, 1, 1, 1, 32'h3333_0000, 0, 1,  0);
        cyc(0, 0, 0, 1, 32'h4444_0001, 0, -1, 1);
        cyc(0, 0, 0, 0, 32'h0,         0, -1, -1);
        do_reset();

        // Hold: m1 stalled three cycles while m0 arrives
        cyc(0, 1, 0, 0, 32'h0, 0, -1, -1);
        chk("hold_addr_c0", s_addr, c_m1_addr);
        cyc(1, 1, 0, 0, 32'h0, 0, -1, -1);
        chk("hold_addr_c1", s_addr, c_m1_addr);
        cyc(1, 1, 0, 0, 32'h0, 0, -1, -1);
        chk("hold_addr_c2", s_addr, c_m1_addr);
        chk("hold_we_c2", {31'b0, s_we}, 32'd1);
        cyc(1, 1, 1, 0, 32'h0,         0, 1, -1);
        cyc(1, 0, 1, 1, 32'h5555_0001, 0, 0,  1);
        cyc(0, 0, 0, 1, 32'h6666_0000, 0, -1, 0);
        cyc(0, 0, 0, 0, 32'h0,         0, -1, -1);
        do_reset();

        // Outstanding limit of two
        cyc(1, 0, 1, 0, 32'h0, 0, 0, -1);
        cyc(0, 1, 1, 0, 32'h0, 0, 1, -1);
        cyc(1, 0, 1, 0, 32'h0, 0, -1, -1);
        chk("full_s_req_a", {31'b0, s_req}, 32'd0);
        cyc(1, 0, 1, 0, 32'h0, 0, -1, -1);
        chk("full_s_req_b", {31'b0, s_req}, 32'd0);
        cyc(1, 0, 1, 1, 32'h7777_0000, 0, 0, 0);
        chk("full_pop_s_req", {31'b0, s_req}, 32'd1);
        cyc(0, 0, 0, 1, 32'h8888_0001, 0, -1, 1);
        cyc(0, 0, 0, 1, 32'h9999_0000, 0, -1, 0);
        cyc(0, 0, 0, 0, 32'h0,         0, -1, -1);
        do_reset();

        // Spurious response, sticky error, reset discards outstanding entries
        cyc(0, 0, 0, 1, 32'h1234_5678, 0, -1, -1);
        cyc(0, 0, 0, 0, 32'h0, 0, -1, -1);
        chk("perr_set", {31'b0, protocol_err}, 32'd1);
        cyc(1, 0, 1, 0, 32'h0, 0, 0, -1);
        chk("perr_held", {31'b0, protocol_err}, 32'd1);
        do_reset();
        cyc(0, 0, 0, 0, 32'h0, 0, -1, -1);
        chk("perr_cleared", {31'b0, protocol_err}, 32'd0);
        cyc(0, 0, 0, 1, 32'hCAFE_0000, 0, -1, -1);
        cyc(0, 0, 0, 0, 32'h0, 0, -1, -1);
        chk("fifo_empty_after_rst", {31'b0, protocol_err}, 32'd1);
        do_reset();

`ifdef DATA_BUS_ARB_PERF_CNT_EN
        cyc(1, 1, 0, 0, 32'h0, 0, -1, -1);
        cyc(1, 1, 0, 0, 32'h0, 0, -1, -1);
        cyc(1, 1, 1, 0, 32'h0,         0, 0, -1);
        cyc(1, 1, 1, 1, 32'hA000_0000, 0, 1,  0);
        cyc(1, 1, 1, 1, 32'hA000_0001, 0, 0,  1);
        cyc(1, 1, 1, 1, 32'hA000_0002, 0, 1,  0);
        cyc(1, 1, 1, 1, 32'hA000_0003, 0, 0,  1);
        cyc(1, 1, 1, 1, 32'hA000_0004, 0, 1,  0);
        cyc(1, 0, 1, 1, 32'hA000_0005, 0, 0,  1);
        cyc(1, 0, 1, 1, 32'hA000_0006, 0, 0,  0);
        cyc(0, 0, 0, 1, 32'hA000_0007, 0, -1, 0);
        chk("m0_grant_cnt", m0_grant_cnt, 32'd5);
        chk("m1_grant_cnt", m1_grant_cnt, 32'd3);
        chk("contention_cnt", contention_cnt, 32'd2);
        do_reset();
`endif

        cyc(0, 0, 0, 0, 32'h0, 0, -1, -1);
        chk("gnt_queue_drained", q_gnt.size(), 32'd0);
        chk("rsp_queue_drained", q_rsp.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
